// File: rtl/pipeline_watchdog_pkg.sv
// Shared definitions for the pipeline run-control watchdog.
//   wd_state_e : watchdog FSM states (RUN, DRAIN, HALTED)
//   CAUSE_*    : bit positions inside the 3-bit one-hot cause vector
//   pack_cause : builds a cause vector from individual fault flags
package watchdog_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wd_state_e;

  localparam int CAUSE_EXC = 0;
  localparam int CAUSE_TMO = 1;
  localparam int CAUSE_RNG = 2;

  function automatic logic [2:0] pack_cause(input logic exc, input logic tmo, input logic rng);
    logic [2:0] c;
    c            = '0;
    c[CAUSE_EXC] = exc;
    c[CAUSE_TMO] = tmo;
    c[CAUSE_RNG] = rng;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_watchdog_if.sv
// Core-side observation bundle seen by the watchdog.
//   pc        : current fetch PC
//   pc_valid  : pc sampled this cycle
//   exception : core exception flag
//   mem_req   : per-port memory request valid
//   mem_addr  : per-port byte address, port i at [i*XLEN +: XLEN]
// master = core/bench driving the signals, slave = watchdog observing them.
interface pipeline_watchdog_if #(
  parameter int XLEN      = 32,
  parameter int NUM_PORTS = 2
);
  logic [XLEN-1:0]           pc;
  logic                      pc_valid;
  logic                      exception;
  logic [NUM_PORTS-1:0]      mem_req;
  logic [NUM_PORTS*XLEN-1:0] mem_addr;

  modport master (output pc, pc_valid, exception, mem_req, mem_addr);
  modport slave  (input  pc, pc_valid, exception, mem_req, mem_addr);
endinterface

// File: rtl/pipeline_watchdog_pc_trace_buf.sv
// pc_trace_buf: circular history of PCs.
//   clk, reset : clock, async active-low reset (entries clear to 0)
//   wr_en      : append wr_data at the write pointer and advance it
//   wr_data    : PC to record
//   rd_idx     : read index, 0 = newest entry
//   rd_data    : entry (wr_ptr-1-rd_idx) mod DEPTH
// DEPTH must be a power of two so the pointer arithmetic wraps naturally.
module pc_trace_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] entry [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (wr_en) begin
      entry[wr_ptr] <= wr_data;
      wr_ptr        <= wr_ptr + AW'(1);
    end
  end

  assign rd_ptr  = wr_ptr - rd_idx - AW'(1);
  assign rd_data = entry[rd_ptr];

endmodule

// File: rtl/pipeline_watchdog.sv
// pipeline_watchdog: run-control watchdog for the three-stage core.
// Detects PC-not-advancing (timeout), core exception and out-of-range memory
// addresses; latches the first cause, drains DRAIN_CYCLES cycles, then holds
// halt until clear.
// Ports:
//   clk, reset   : clock, async active-low reset
//   bus          : pipeline_watchdog_if.slave (pc, pc_valid, exception, mem_req, mem_addr)
//   clear        : return to RUN, clear cause/counters (beats any fault)
//   halt         : DRAIN or HALTED
//   halted       : state == HALTED
//   cause        : latched one-hot {range, timeout, exception}
//   stall_count  : cycles the PC has not advanced
//   fault_port   : lowest port index of a range fault
//   fault_addr   : offending address of that port
//   trace_idx/trace_pc : PC history read port (PIPELINE_WATCHDOG_TRACE_EN only)
// Optional feature macro: PIPELINE_WATCHDOG_TRACE_EN adds the PC history buffer.
//
// state  | meaning
// RUN    | monitoring; stall counter active, faults evaluated
// DRAIN  | fault latched, halt asserted, counting DRAIN_CYCLES
// HALTED | halt and halted held until clear
module pipeline_watchdog
  import watchdog_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_PORTS    = 2,
  parameter int MEM_LOG2     = 17,
  parameter int TIMEOUT_W    = 8,
  parameter int TIMEOUT      = 100,
  parameter int DRAIN_CYCLES = 1,
  parameter int TRACE_DEPTH  = 8,
  localparam int FP_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int DC_W        = $clog2(DRAIN_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_watchdog_if.slave    bus,
  input  logic                  clear,
  output logic                  halt,
  output logic                  halted,
  output logic [2:0]            cause,
  output logic [TIMEOUT_W-1:0]  stall_count,
  output logic [FP_W-1:0]       fault_port,
  output logic [XLEN-1:0]       fault_addr
`ifdef PIPELINE_WATCHDOG_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [XLEN-1:0]                trace_pc
`endif
);

  if (NUM_PORTS < 1 || DRAIN_CYCLES < 1 || MEM_LOG2 >= XLEN ||
      TIMEOUT >= (2**TIMEOUT_W) - 1 || TRACE_DEPTH < 2 ||
      (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_params
    $error("pipeline_watchdog: illegal parameter combination");
  end

  wd_state_e        state;
  logic [XLEN-1:0]  prev_pc;
  logic [DC_W-1:0]  drain_cnt;

  logic [NUM_PORTS-1:0] bad_port;
  logic                 rng, tmo, exc;
  logic [FP_W-1:0]      rng_port;
  logic [XLEN-1:0]      rng_addr;
  logic [2:0]           fault_vec;

  // Descending scan so the lowest failing port is the one that sticks.
  always_comb begin
    bad_port = '0;
    rng_port = '0;
    rng_addr = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      bad_port[i] = bus.mem_req[i] &&
                    (bus.mem_addr[i*XLEN + MEM_LOG2 +: XLEN - MEM_LOG2] != '0);
      if (bad_port[i]) begin
        rng_port = FP_W'(i);
        rng_addr = bus.mem_addr[i*XLEN +: XLEN];
      end
    end
  end

  assign exc       = bus.exception;
  assign rng       = |bad_port;
  assign tmo       = stall_count > TIMEOUT_W'(TIMEOUT);
  assign fault_vec = pack_cause(exc, tmo, rng);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      prev_pc     <= '0;
      stall_count <= '0;
      drain_cnt   <= '0;
      cause       <= '0;
      fault_port  <= '0;
      fault_addr  <= '0;
      halt        <= 1'b0;
      halted      <= 1'b0;
    end else if (clear) begin
      state       <= RUN;
      stall_count <= '0;
      drain_cnt   <= '0;
      cause       <= '0;
      fault_port  <= '0;
      fault_addr  <= '0;
      halt        <= 1'b0;
      halted      <= 1'b0;
      if (bus.pc_valid) prev_pc <= bus.pc;
    end else begin
      case (state)
        RUN: begin
          if (bus.pc_valid) begin
            prev_pc <= bus.pc;
            if (bus.pc == prev_pc) begin
              if (stall_count != '1) stall_count <= stall_count + TIMEOUT_W'(1);
            end else begin
              stall_count <= '0;
            end
          end
          if (|fault_vec) begin
            state     <= DRAIN;
            cause     <= fault_vec;
            drain_cnt <= '0;
            halt      <= 1'b1;
            if (rng) begin
              fault_port <= rng_port;
              fault_addr <= rng_addr;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DC_W'(1);
          if (drain_cnt == DC_W'(DRAIN_CYCLES - 1)) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: ;
        default: begin
          state  <= RUN;
          halt   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPELINE_WATCHDOG_TRACE_EN
  // History freezes once the watchdog leaves RUN so the lead-up to the fault survives.
  logic trace_we;
  assign trace_we = (state == RUN) && bus.pc_valid && (bus.pc != prev_pc);

  pc_trace_buf #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (trace_we),
    .wr_data (bus.pc),
    .rd_idx  (trace_idx),
    .rd_data (trace_pc)
  );
`endif

endmodule
